// File: rtl/spi_cnt_ctrl_pkg.sv
// Shared types and register map for the SPI counter-configuration controller.
package spi_cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DISCARD
  } ctrl_state_t;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_PRESC   = 4'd1;
  localparam logic [3:0] REG_LIMIT   = 4'd2;
  localparam logic [3:0] REG_SCRATCH = 4'd3;

  localparam int unsigned CTRL_RUN_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CMD_WR_BIT   = 7;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cnt_ctrl_sync_2ff.sv
// Two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_cnt_ctrl.sv
// Frame parser behind spi_slave: SS-delimited write frames update the
// up-counter configuration registers (CTRL, PRESCALE, LIMIT, SCRATCH).
module spi_cnt_ctrl #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [7:0]  PRESC_RST = 8'd0,
  parameter logic [7:0]  LIMIT_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ss,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cnt_run,
  output logic       cnt_clear,
  output logic [7:0] cnt_prescale,
  output logic [7:0] cnt_limit,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  import spi_cnt_ctrl_pkg::*;

  localparam logic [4:0] NREGS     = 5'(NUM_REGS);
  localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);

  logic        ss_s;
  ctrl_state_t state_q, state_d;
  logic [3:0]  addr_ptr_q, addr_ptr_d;
  logic        wr_seen_q, wr_seen_d;
  logic        run_q, run_d;
  logic        clear_q, clear_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  limit_q, limit_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  err_q, err_d;
  logic        armed_q, armed_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic [3:0]  cmd_addr;

  sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d    (ss),
    .q    (ss_s)
  );

  // Next-state logic: frame parsing, register writes and frame/error counting.
  always_comb begin
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    wr_seen_d  = wr_seen_q;
    run_d      = run_q;
    clear_d    = 1'b0;
    presc_d    = presc_q;
    limit_d    = limit_q;
    scratch_d  = scratch_q;
    frame_d    = frame_q;
    err_d      = err_q;
    cmd_addr   = rx_data[3:0];

    // The synchronizer's reset value is not a real ss sample; only arm once a
    // genuinely sampled ss=1 has reached ss_s, so a frame cut by reset never resumes.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (ss_s & sync_vld_q[1]);

    case (state_q)
      IDLE: begin
        if (armed_q && !ss_s) state_d = CMD;
      end
      CMD: begin
        if (rx_done) begin
          if (rx_data[CMD_WR_BIT] && ({1'b0, cmd_addr} < NREGS)) begin
            addr_ptr_d = cmd_addr;
            state_d    = DATA;
          end else begin
            err_d   = sat_inc8(err_q);
            state_d = DISCARD;
          end
        end
      end
      DATA: begin
        if (rx_done) begin
          wr_seen_d  = 1'b1;
          addr_ptr_d = (addr_ptr_q == LAST_ADDR) ? '0 : addr_ptr_q + 4'd1;
          case (addr_ptr_q)
            REG_CTRL: begin
              run_d   = rx_data[CTRL_RUN_BIT];
              clear_d = rx_data[CTRL_CLR_BIT];
            end
            REG_PRESC:   presc_d   = rx_data;
            REG_LIMIT:   limit_d   = rx_data;
            REG_SCRATCH: scratch_d = rx_data;
            default: ;
          endcase
        end
      end
      DISCARD: ;
      default: state_d = IDLE;
    endcase

    // Frame end overrides the state but keeps this cycle's byte; wr_seen_d
    // already includes a write made in the same cycle.
    if (ss_s) begin
      if (state_q == DATA && wr_seen_d) frame_d = frame_q + 8'd1;
      state_d   = IDLE;
      wr_seen_d = 1'b0;
    end
  end

  // State and register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_ptr_q <= '0;
      wr_seen_q  <= 1'b0;
      run_q      <= 1'b0;
      clear_q    <= 1'b0;
      presc_q    <= PRESC_RST;
      limit_q    <= LIMIT_RST;
      scratch_q  <= '0;
      frame_q    <= '0;
      err_q      <= '0;
      armed_q    <= 1'b0;
      sync_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_ptr_q <= addr_ptr_d;
      wr_seen_q  <= wr_seen_d;
      run_q      <= run_d;
      clear_q    <= clear_d;
      presc_q    <= presc_d;
      limit_q    <= limit_d;
      scratch_q  <= scratch_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      sync_vld_q <= sync_vld_d;
    end
  end

  assign cnt_run      = run_q;
  assign cnt_clear    = clear_q;
  assign cnt_prescale = presc_q;
  assign cnt_limit    = limit_q;
  assign frame_cnt    = frame_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_spi_cnt_ctrl.sv
// Bench for spi_cnt_ctrl: directed frames plus random traffic, every cycle
// compared against a frame-level behavioural model.
module tb_spi_cnt_ctrl;

  import spi_cnt_ctrl_pkg::*;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss      = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cnt_run, cnt_clear;
  logic [7:0] cnt_prescale, cnt_limit, frame_cnt, err_cnt;

  always #5 clk = ~clk;

  spi_cnt_ctrl #(.NUM_REGS(4), .PRESC_RST(8'h00), .LIMIT_RST(8'hFF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ss          (ss),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .cnt_run     (cnt_run),
    .cnt_clear   (cnt_clear),
    .cnt_prescale(cnt_prescale),
    .cnt_limit   (cnt_limit),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int clr_seen = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ss seen by the frame logic is ss from two clocks ago; a frame opens on a
  // low ss (once a real high has been seen), bytes are: one command, then data
  // written to reg[ptr] with ptr cycling mod 4; a high ss closes the frame.
  logic       m_run = 0, m_clr = 0;
  logic [7:0] m_presc = 8'h00, m_limit = 8'hFF, m_scr = 8'h00;
  logic [7:0] m_frame = 8'h00, m_err = 8'h00;
  logic       m_in_frame = 0, m_have_cmd = 0, m_bad = 0, m_wrote = 0, m_armed = 0;
  int         m_ptr = 0;
  logic       sh1 = 1, sh2 = 1, sh1v = 0, sh2v = 0, m_ssv = 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_clr = 0; m_presc = 8'h00; m_limit = 8'hFF; m_scr = 8'h00;
      m_frame = 8'h00; m_err = 8'h00;
      m_in_frame = 0; m_have_cmd = 0; m_bad = 0; m_wrote = 0; m_armed = 0; m_ptr = 0;
      sh1 = 1; sh2 = 1; sh1v = 0; sh2v = 0;
    end else begin
      m_ssv = sh2;
      m_clr = 0;
      if (!m_in_frame) begin
        if (m_armed && !m_ssv) begin
          m_in_frame = 1; m_have_cmd = 0; m_bad = 0; m_wrote = 0;
        end
      end else if (rx_done) begin
        if (m_have_cmd) begin
          case (m_ptr)
            0: begin m_run = rx_data[0]; m_clr = rx_data[1]; end
            1: m_presc = rx_data;
            2: m_limit = rx_data;
            default: m_scr = rx_data;
          endcase
          m_ptr = (m_ptr + 1) % 4;
          m_wrote = 1;
        end else if (!m_bad) begin
          if (rx_data[7] && rx_data[3:0] < 4'd4) begin
            m_have_cmd = 1;
            m_ptr = int'(rx_data[3:0]);
          end else begin
            m_bad = 1;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
          end
        end
      end
      if (m_in_frame && m_ssv) begin
        if (m_wrote) m_frame = m_frame + 8'd1;
        m_in_frame = 0;
      end
      if (m_ssv && sh2v) m_armed = 1;
      sh2 = sh1; sh2v = sh1v;
      sh1 = ss;  sh1v = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("run", {7'b0, cnt_run}, {7'b0, m_run});
    chk("clear", {7'b0, cnt_clear}, {7'b0, m_clr});
    chk("prescale", cnt_prescale, m_presc);
    chk("limit", cnt_limit, m_limit);
    chk("scratch", dut.scratch_q, m_scr);
    chk("frame_cnt", frame_cnt, m_frame);
    chk("err_cnt", err_cnt, m_err);
    if (cnt_clear) clr_seen++;
  end

  // ---------------- stimulus ----------------
  logic [7:0] fbuf [8];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    if (gap > 0) tick(gap);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic set4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    fbuf[0] = b0; fbuf[1] = b1; fbuf[2] = b2; fbuf[3] = b3;
  endtask

  // Send fbuf[0..n-1] inside one SS frame; coinc makes the last byte land
  // in the same cycle the synchronized SS rises.
  task automatic frame(input int n, input int gap_max, input bit coinc);
    ss = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      if (coinc && i == n - 1) begin
        ss = 1'b1;
        tick(2);
        send(fbuf[i], 0);
      end else begin
        send(fbuf[i], int'($urandom_range(gap_max, 0)));
      end
    end
    if (!coinc) begin
      tick(1);
      ss = 1'b1;
    end
    tick(4);
  endtask

  initial begin
    // 1: reset values
    reset_n = 1'b0;
    tick(3);
    chk("t1_run", {7'b0, cnt_run}, 8'h00);
    chk("t1_presc", cnt_prescale, 8'h00);
    chk("t1_limit", cnt_limit, 8'hFF);
    chk("t1_frame", frame_cnt, 8'h00);
    chk("t1_err", err_cnt, 8'h00);
    reset_n = 1'b1;
    tick(6);

    // 2: CTRL/PRESC/LIMIT write (0x05 has bit1 clear, so no clear pulse)
    set4(8'h80, 8'h05, 8'h10, 8'h40);
    frame(4, 2, 0);
    chk("t2_run", {7'b0, cnt_run}, 8'h01);
    chk("t2_presc", cnt_prescale, 8'h10);
    chk("t2_limit", cnt_limit, 8'h40);
    chk("t2_frame", frame_cnt, 8'h01);
    chk("t2_clr_cycles", 8'(clr_seen), 8'h00);

    // 3: start at SCRATCH, wrap to CTRL and PRESC
    set4(8'h83, 8'hAA, 8'h11, 8'h22);
    frame(4, 2, 0);
    chk("t3_scratch", dut.scratch_q, 8'hAA);
    chk("t3_run", {7'b0, cnt_run}, 8'h01);
    chk("t3_presc", cnt_prescale, 8'h22);
    chk("t3_limit", cnt_limit, 8'h40);
    chk("t3_frame", frame_cnt, 8'h02);

    // clear pulse: CTRL=0x03 -> run=1, exactly one clear cycle
    set4(8'h80, 8'h03, 8'h00, 8'h00);
    frame(2, 0, 0);
    chk("clr_cycles", 8'(clr_seen), 8'h01);
    chk("clr_frame", frame_cnt, 8'h03);

    // 4: read command and out-of-range address are rejected
    set4(8'h05, 8'h77, 8'h00, 8'h00);
    frame(2, 1, 0);
    set4(8'h8F, 8'h77, 8'h00, 8'h00);
    frame(2, 1, 0);
    chk("t4_err", err_cnt, 8'h02);
    chk("t4_frame", frame_cnt, 8'h03);
    chk("t4_presc", cnt_prescale, 8'h22);
    chk("t4_limit", cnt_limit, 8'h40);

    // CMD-only frame: no change, no error
    set4(8'h81, 8'h00, 8'h00, 8'h00);
    frame(1, 0, 0);
    chk("cmdonly_frame", frame_cnt, 8'h03);
    chk("cmdonly_err", err_cnt, 8'h02);

    // 5: last byte coincides with SS rise
    set4(8'h81, 8'h55, 8'h00, 8'h00);
    frame(2, 0, 1);
    chk("t5_presc", cnt_prescale, 8'h55);
    chk("t5_frame", frame_cnt, 8'h04);
    chk("t5_state", {6'b0, dut.state_q}, {6'b0, IDLE});

    // 6: reset mid-frame; following bytes ignored until SS toggles
    ss = 1'b0;
    tick(4);
    send(8'h82, 0);
    tick(1);
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    chk("t6_limit_rst", cnt_limit, 8'hFF);
    chk("t6_frame_rst", frame_cnt, 8'h00);
    send(8'h33, 1);
    send(8'h44, 1);
    tick(2);
    chk("t6_limit_ign", cnt_limit, 8'hFF);
    chk("t6_state", {6'b0, dut.state_q}, {6'b0, IDLE});
    ss = 1'b1;
    tick(4);
    set4(8'h82, 8'h12, 8'h00, 8'h00);
    frame(2, 0, 0);
    chk("t6_limit_new", cnt_limit, 8'h12);
    chk("t6_frame_new", frame_cnt, 8'h01);

    // random frames
    repeat (150) begin
      int n;
      n = int'($urandom_range(6, 1));
      fbuf[0] = {($urandom_range(3, 0) != 0), 3'($urandom), 4'($urandom_range(5, 0))};
      for (int i = 1; i < 8; i++) fbuf[i] = 8'($urandom);
      frame(n, 3, ($urandom_range(4, 0) == 0));
    end

    // error counter saturation
    repeat (260) begin
      fbuf[0] = 8'($urandom) & 8'h7F;
      frame(1, 0, 0);
    end
    chk("err_sat", err_cnt, 8'hFF);

    // frame counter wrap after fresh reset
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    repeat (257) begin
      fbuf[0] = 8'h83;
      fbuf[1] = 8'($urandom);
      frame(2, 0, 0);
    end
    chk("frame_wrap", frame_cnt, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
